// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants, entry type and pointer sizing for the fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int FETCH_ADDR_WIDTH  = 16;
  localparam int FETCH_INSTR_WIDTH = 32;

  // Default-width entry; modules with other widths declare a same-named local struct.
  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0]  pc;
    logic [FETCH_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Never returns zero so a degenerate depth still yields a legal vector.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous DEPTH-entry FIFO with push/pop/count and clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 4,
  localparam int PW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [PW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW:0]      r_count;

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (push && !rst && !clear) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module      : fetch_buffer
// Description : Issues instruction-memory reads from the PC stream and buffers
//               {pc, instr} pairs for decode with credit-based PC backpressure.
//               Optional macro FETCH_BYPASS_EN forwards a response straight to
//               the outputs when the buffer is empty and decode is ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  input  logic                   pc_valid,
  output logic                   pc_stall,
  input  logic                   flush,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic                   imem_rd_en,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready
);

  localparam int PW = ptr_width(DEPTH);
  localparam int EW = ADDR_WIDTH + INSTR_WIDTH;

  localparam logic [INSTR_WIDTH-1:0] c_nop = INSTR_WIDTH'(NOP_INSTR);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;

  logic         w_issue;
  logic         w_resp;
  logic         w_bypass;
  logic         w_push;
  logic         w_pop;
  logic         w_empty;
  logic [PW:0]  w_count;
  fetch_entry_t w_push_entry;
  fetch_entry_t w_head;

  // Credit: every outstanding read already owns a slot, so a push never overflows.
  assign pc_stall = ({1'b0, w_count} + (PW+2)'(r_inflight)) >= (PW+2)'(DEPTH);

  assign w_issue    = pc_valid && !pc_stall && !flush && !rst;
  assign imem_rd_en = w_issue;
  assign imem_addr  = pc_in;

  assign w_resp  = r_inflight && !flush && !rst;
  assign w_empty = (w_count == '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_resp && w_empty && instr_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push       = w_resp && !w_bypass;
  assign w_pop        = !w_empty && instr_ready && !flush;
  assign w_push_entry = '{pc: r_inflight_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_inflight_pc <= pc_in;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (w_count)
  );

  always_comb begin
    instr_valid = 1'b0;
    instr_out   = c_nop;
    instr_pc    = '0;
    if (w_bypass) begin
      instr_valid = 1'b1;
      instr_out   = imem_rdata;
      instr_pc    = r_inflight_pc;
    end else if (!w_empty) begin
      instr_valid = 1'b1;
      instr_out   = w_head.instr;
      instr_pc    = w_head.pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Directed self-checking bench for fetch_buffer (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_buffer;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_in = '0;
  logic        pc_valid = 1'b0;
  logic        pc_stall;
  logic        flush = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  fetch_buffer #(
    .ADDR_WIDTH  (16),
    .INSTR_WIDTH (32),
    .DEPTH       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_stall    (pc_stall),
    .flush       (flush),
    .imem_addr   (imem_addr),
    .imem_rd_en  (imem_rd_en),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [15:0] a);
    return 32'hA0 + {18'b0, a[15:2]};
  endfunction

  // One-cycle read latency memory model.
  always @(posedge clk) begin
    imem_rdata <= imem_rd_en ? mem_val(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; pc_valid = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; pc_valid = 1'b1; pc_in = 16'h1234; flush = 1'b0; instr_ready = 1'b1;
    cyc();
    @(negedge clk);
    n_cmp++; if (imem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en_during_rst: got %b expected 0", imem_rd_en); end
    cyc();
    rst = 1'b0; pc_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (instr_out !== 32'h0000_0013) begin n_err++; $display("FAIL reset_instr_out: got %h expected 00000013", instr_out); end
    n_cmp++; if (instr_pc !== 16'h0000) begin n_err++; $display("FAIL reset_instr_pc: got %h expected 0000", instr_pc); end
    n_cmp++; if (pc_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", pc_stall); end
    n_cmp++; if (imem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b expected 0", imem_rd_en); end
    cyc();
  endtask

  task automatic test_stream;
    logic exp_v;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pc_valid = (k < 3);
      pc_in    = 16'(4 * k);
      @(negedge clk);
      n_cmp++; if (imem_rd_en !== (k < 3)) begin n_err++; $display("FAIL stream_rd_en[%0d]: got %b expected %b", k, imem_rd_en, (k < 3)); end
      exp_v = (k >= LAT) && (k - LAT < 3);
      n_cmp++; if (instr_valid !== exp_v) begin n_err++; $display("FAIL stream_valid[%0d]: got %b expected %b", k, instr_valid, exp_v); end
      if (exp_v) begin
        n_cmp++;
        if (instr_pc !== 16'(4 * (k - LAT)) || instr_out !== 32'hA0 + 32'(k - LAT)) begin
          n_err++;
          $display("FAIL stream_head[%0d]: got pc=%h instr=%h expected pc=%h instr=%h",
                   k, instr_pc, instr_out, 16'(4 * (k - LAT)), 32'hA0 + 32'(k - LAT));
        end
      end
      cyc();
    end
    pc_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    int issued;
    issued = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      pc_valid = 1'b1;
      pc_in    = 16'h0100 + 16'(4 * issued);
      @(negedge clk);
      if (imem_rd_en) issued++;
      cyc();
    end
    pc_valid = 1'b1;
    pc_in    = 16'h0100 + 16'(4 * issued);
    @(negedge clk);
    n_cmp++; if (issued !== 4) begin n_err++; $display("FAIL bp_issued: got %0d expected 4", issued); end
    n_cmp++; if (pc_stall !== 1'b1) begin n_err++; $display("FAIL bp_stall_full: got %b expected 1", pc_stall); end
    n_cmp++; if (imem_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en_full: got %b expected 0", imem_rd_en); end
    cyc();
    pc_valid = 1'b0; instr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_cmp++; if (pc_stall !== (j == 0)) begin n_err++; $display("FAIL bp_stall[%0d]: got %b expected %b", j, pc_stall, (j == 0)); end
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'h0100 + 16'(4 * j) || instr_out !== 32'hE0 + 32'(j)) begin
        n_err++;
        $display("FAIL bp_pop[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 j, instr_valid, instr_pc, instr_out, 16'h0100 + 16'(4 * j), 32'hE0 + 32'(j));
      end
      cyc();
    end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b expected 0", instr_valid); end
    cyc();
    instr_ready = 1'b0;
  endtask

  task automatic test_wrap;
    logic [15:0] q[$];
    logic [15:0] exp_pc;
    logic [7:0]  pat;
    int issued;
    int got;
    issued = 0; got = 0; pat = 8'b1011_0111;
    do_reset();
    for (int c = 0; c < 80 && got < 10; c++) begin
      pc_valid    = (issued < 10);
      pc_in       = 16'h0200 + 16'(4 * issued);
      instr_ready = (c < 6) ? 1'b0 : pat[c % 8];
      @(negedge clk);
      if (c == 5) begin
        n_cmp++; if (pc_stall !== 1'b1) begin n_err++; $display("FAIL wrap_full_stall: got %b expected 1", pc_stall); end
      end
      if (imem_rd_en) begin q.push_back(pc_in); issued++; end
      if (instr_valid && instr_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL wrap_spurious: got pc=%h expected no entry", instr_pc);
        end else begin
          exp_pc = q.pop_front();
          if (instr_pc !== exp_pc || instr_out !== mem_val(exp_pc)) begin
            n_err++;
            $display("FAIL wrap_order[%0d]: got pc=%h instr=%h expected pc=%h instr=%h",
                     got, instr_pc, instr_out, exp_pc, mem_val(exp_pc));
          end
        end
        got++;
      end
      cyc();
    end
    n_cmp++; if (got !== 10) begin n_err++; $display("FAIL wrap_count: got %0d expected 10", got); end
    pc_valid = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_flush;
    do_reset();
    pc_valid = 1'b1; pc_in = 16'h0008;
    cyc();
    pc_in = 16'h0010;
    @(negedge clk);
    n_cmp++; if (imem_rd_en !== 1'b1) begin n_err++; $display("FAIL flush_issue_0010: got %b expected 1", imem_rd_en); end
    cyc();
    flush = 1'b1; pc_in = 16'h0014;
    @(negedge clk);
    n_cmp++; if (imem_rd_en !== 1'b0) begin n_err++; $display("FAIL flush_no_issue: got %b expected 0", imem_rd_en); end
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0008) begin n_err++; $display("FAIL flush_prior_head: got v=%b pc=%h expected v=1 pc=0008", instr_valid, instr_pc); end
    cyc();
    flush = 1'b0; pc_in = 16'h0040; instr_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid_after: got %b expected 0", instr_valid); end
    n_cmp++; if (pc_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall_after: got %b expected 0", pc_stall); end
    n_cmp++; if (imem_rd_en !== 1'b1) begin n_err++; $display("FAIL flush_issue_0040: got %b expected 1", imem_rd_en); end
    cyc();
    pc_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_cmp++; if (instr_valid !== (k == LAT)) begin n_err++; $display("FAIL flush_out_valid[%0d]: got %b expected %b", k, instr_valid, (k == LAT)); end
      if (k == LAT) begin
        n_cmp++;
        if (instr_pc !== 16'h0040 || instr_out !== 32'h0000_00B0) begin
          n_err++; $display("FAIL flush_first_out: got pc=%h instr=%h expected pc=0040 instr=000000b0", instr_pc, instr_out);
        end
      end
      cyc();
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pc_valid = 1'b1; pc_in = 16'h0300 + 16'(4 * k);
      cyc();
    end
    pc_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (pc_stall !== 1'b1) begin n_err++; $display("FAIL rstmid_stall: got %b expected 1", pc_stall); end
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0300) begin n_err++; $display("FAIL rstmid_head: got v=%b pc=%h expected v=1 pc=0300", instr_valid, instr_pc); end
    rst = 1'b1;
    cyc();
    rst = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (instr_out !== 32'h0000_0013 || instr_pc !== 16'h0000) begin n_err++; $display("FAIL rstmid_outs: got pc=%h instr=%h expected pc=0000 instr=00000013", instr_pc, instr_out); end
    n_cmp++; if (pc_stall !== 1'b0) begin n_err++; $display("FAIL rstmid_stall_clr: got %b expected 0", pc_stall); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_stale[%0d]: got %b expected 0", k, instr_valid); end
    end
    cyc();
    instr_ready = 1'b0;
  endtask

  task automatic test_latency;
    do_reset();
    instr_ready = 1'b1; pc_valid = 1'b1; pc_in = 16'h0020;
    @(negedge clk);
    n_cmp++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0020) begin n_err++; $display("FAIL lat_issue: got en=%b addr=%h expected en=1 addr=0020", imem_rd_en, imem_addr); end
    cyc();
    pc_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_cmp++; if (instr_valid !== (k == LAT)) begin n_err++; $display("FAIL lat_valid[%0d]: got %b expected %b", k, instr_valid, (k == LAT)); end
      if (k == LAT) begin
        n_cmp++;
        if (instr_pc !== 16'h0020 || instr_out !== 32'h0000_00A8) begin
          n_err++; $display("FAIL lat_data: got pc=%h instr=%h expected pc=0020 instr=000000a8", instr_pc, instr_out);
        end
      end
      cyc();
    end
    instr_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc();
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
